// File: rtl/sram_burst_adapter_if.sv
// Avalon-MM bus bundle shared by the upstream burst port and the downstream
// single-word port of sram_burst_adapter.
interface sram_burst_adapter_if #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0]  address;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic [BURST_W-1:0] burstcount;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (
    output address, read, write, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sram_burst_adapter.sv
// Splits Avalon-MM burst reads/writes into single-word transfers for the SRAM controller.
// Optional macro SRAM_BURST_WRAP_ERR_EN enables the sticky address-wrap error flag err_o.
module sram_burst_adapter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sram_burst_adapter_if.slave   s,
  sram_burst_adapter_if.master  m,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DRAIN,
    WR_ISSUE,
    WR_DATA
  } state_t;

  state_t             state;
  logic [BURST_W-1:0] cnt;
  logic [BURST_W-1:0] rd_out;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               rd_q;
  logic               wr_q;

  logic [BURST_W-1:0] s_count;
  logic               rd_issue;
  logic               wr_issue;
  logic               rdv_seen;

  assign s_count  = (s.burstcount == '0) ? BURST_W'(1) : s.burstcount;
  assign rd_issue = rd_q & ~m.waitrequest;
  assign wr_issue = wr_q & ~m.waitrequest;
  // A valid arriving with nothing outstanding is a leftover from before a reset.
  assign rdv_seen = m.readdatavalid & (rd_out != '0);

  assign m.address    = addr_q;
  assign m.read       = rd_q;
  assign m.write      = wr_q;
  assign m.writedata  = wdata_q;
  assign m.burstcount = BURST_W'(1);

  assign s.readdata      = m.readdata;
  assign s.readdatavalid = m.readdatavalid;
  assign s.waitrequest   = rst_i | ~((state == IDLE) | (state == WR_DATA));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_out  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      if (rd_issue && !rdv_seen) begin
        rd_out <= rd_out + BURST_W'(1);
      end else if (!rd_issue && rdv_seen) begin
        rd_out <= rd_out - BURST_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (s.read) begin
            addr_q <= s.address;
            cnt    <= s_count;
            rd_q   <= 1'b1;
            state  <= RD_ISSUE;
          end else if (s.write) begin
            addr_q  <= s.address;
            cnt     <= s_count;
            wdata_q <= s.writedata;
            wr_q    <= 1'b1;
            state   <= WR_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (rd_issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt    <= cnt - BURST_W'(1);
            if (cnt == BURST_W'(1)) begin
              rd_q  <= 1'b0;
              state <= RD_DRAIN;
            end
          end
        end
        RD_DRAIN: begin
          if (rd_out == '0) state <= IDLE;
        end
        WR_ISSUE: begin
          if (wr_issue) begin
            wr_q   <= 1'b0;
            addr_q <= addr_q + ADDR_W'(1);
            cnt    <= cnt - BURST_W'(1);
            state  <= (cnt == BURST_W'(1)) ? IDLE : WR_DATA;
          end
        end
        WR_DATA: begin
          if (s.write) begin
            wdata_q <= s.writedata;
            wr_q    <= 1'b1;
            state   <= WR_ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_BURST_WRAP_ERR_EN
  localparam int SUM_W = ADDR_W + BURST_W;

  logic [SUM_W-1:0] last_addr;
  logic             first_beat;

  // Any bit above the address range means the burst runs past the top and wraps.
  assign last_addr  = SUM_W'(s.address) + SUM_W'(s_count) - SUM_W'(1);
  assign first_beat = (state == IDLE) & (s.read | s.write);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (first_beat && (|last_addr[SUM_W-1:ADDR_W])) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule
